// File: rtl/sw_playback_pkg.sv
// Shared types and defaults for the switch-snapshot record/replay block.
package sw_playback_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } pb_state_t;

  localparam int unsigned DEF_DW    = 10;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_AW    = 4;
  localparam int unsigned DEF_TICKS = 100_000_000;

  // Counter width for n states; never narrower than one bit.
  function automatic int unsigned pb_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/playback_mem.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
module playback_mem #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sw_playback.sv
// Record-and-replay reader: appends captured switch words, then shows each
// stored word on the LEDs for a fixed number of cycles with its index.
module sw_playback
  import sw_playback_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned TICKS = DEF_TICKS
) (
  input  logic          clk100_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          play_i,
  input  logic          stop_i,
  input  logic          clear_i,
  input  logic          loop_i,
  output logic [DW-1:0] ledr_o,
  output logic [AW-1:0] idx_o,
  output logic [AW:0]   count_o,
  output logic          busy_o,
  output logic          full_o
);

  localparam int unsigned TW = pb_width(TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

  pb_state_t     r_state;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [TW-1:0] r_tick;
  logic [DW-1:0] r_ledr;
  logic [AW-1:0] r_idx;

  logic [DW-1:0] w_rdata;
  logic          w_full;
  logic          w_play_go;
  logic          w_we;
  logic          w_last;

  assign w_full    = (r_count == CNT_FULL);
  assign w_play_go = (r_state == IDLE) && play_i && (r_count != '0);
  // Writes lose to every higher-priority event in the same cycle.
  assign w_we      = !rst_i && !clear_i && (r_state == IDLE) && !w_play_go
                     && wr_en_i && !w_full;
  assign w_last    = ({1'b0, r_rd_ptr} == (r_count - (AW + 1)'(1)));

  playback_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (clk100_i),
    .i_we    (w_we),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata (wr_data_i),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_tick   <= '0;
      r_ledr   <= '0;
      r_idx    <= '0;
    end else if (clear_i) begin
      r_state <= IDLE;
      r_count <= '0;
      r_ledr  <= '0;
      r_idx   <= '0;
    end else if (stop_i && (r_state != IDLE)) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_play_go) begin
            r_rd_ptr <= '0;
            r_state  <= FETCH;
          end else if (w_we) begin
            r_count <= r_count + (AW + 1)'(1);
          end
        end
        FETCH: begin
          r_tick  <= '0;
          r_state <= SHOW;
        end
        SHOW: begin
          // Read data lands during the first SHOW cycle; latch it there.
          if (r_tick == '0) begin
            r_ledr <= w_rdata;
            r_idx  <= r_rd_ptr;
          end
          if (r_tick == TICK_LAST) begin
            if (!w_last) begin
              r_rd_ptr <= r_rd_ptr + AW'(1);
              r_state  <= FETCH;
            end else if (loop_i) begin
              r_rd_ptr <= '0;
              r_state  <= FETCH;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ledr_o  = r_ledr;
  assign idx_o   = r_idx;
  assign count_o = r_count;
  assign busy_o  = (r_state != IDLE);
  assign full_o  = w_full;

endmodule
